// File: rtl/key_menu_sequencer.sv
// ---------------------------------------------------------------------------
// key_menu_sequencer
//
// Purpose
//   Turns the debounced one-cycle key pulses (Prev / Next / Okay / Cancel) into
//   TFT43 menu navigation. The user browses items, edits a per-item value and
//   commits it to a configuration target over a req/ack handshake. Keys are
//   queued in a small FIFO so presses made while a commit is outstanding are
//   applied once the target has answered. A one-cycle refresh pulse is raised
//   whenever something the display shows has changed.
//
// Ports
//   clk           in   1      system clock (80 MHz)
//   rst_n         in   1      asynchronous active-low reset
//   en            in   1      block enable; low = synchronous flush
//   key_pulse     in   4      [0]Prev [1]Next [2]Okay [3]Cancel pulses
//   menu_idx      out  IDX_W  current item index
//   edit_val      out  VAL_W  value under edit (stored value when browsing)
//   editing       out  1      high while editing a value
//   cfg_req       out  1      commit request, held until cfg_ack
//   cfg_addr      out  IDX_W  commit item index, stable while cfg_req
//   cfg_data      out  VAL_W  commit value, stable while cfg_req
//   cfg_ack       in   1      target accepts commit (sampled while cfg_req)
//   disp_refresh  out  1      one-cycle pulse after any visible change
//   key_ovf       out  1      sticky: a key was dropped (FIFO full / collision)
//
// Build option
//   MENU_TIMEOUT_EN : when defined, EDIT with no key popped for TIMEOUT_CYC
//                     consecutive cycles is abandoned as if Cancel was pressed.
//                     When undefined, EDIT is held indefinitely.
// ---------------------------------------------------------------------------
module key_menu_sequencer #(
    parameter int NUM_ITEMS   = 8,
    parameter int IDX_W       = 3,
    parameter int VAL_W       = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 800_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       key_pulse,
    output logic [IDX_W-1:0] menu_idx,
    output logic [VAL_W-1:0] edit_val,
    output logic             editing,
    output logic             cfg_req,
    output logic [IDX_W-1:0] cfg_addr,
    output logic [VAL_W-1:0] cfg_data,
    input  logic             cfg_ack,
    output logic             disp_refresh,
    output logic             key_ovf
);

    // Elaboration-time sanity checks on the configuration.
    if (NUM_ITEMS < 2 || (1 << IDX_W) < NUM_ITEMS || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("key_menu_sequencer: illegal parameter combination");
    end

    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ITEMS - 1);
    localparam logic [VAL_W-1:0] VAL_MAX   = '1;
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    // Key codes as stored in the FIFO.
    localparam logic [1:0] KEY_PREV   = 2'd0;
    localparam logic [1:0] KEY_NEXT   = 2'd1;
    localparam logic [1:0] KEY_OKAY   = 2'd2;
    localparam logic [1:0] KEY_CANCEL = 2'd3;

    typedef enum logic [1:0] {
        S_BROWSE   = 2'd0,
        S_EDIT     = 2'd1,
        S_COMMIT   = 2'd2,
        S_WAIT_ACK = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VAL_W-1:0] val_q, val_d;
    logic             req_q, req_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic [VAL_W-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic             refresh_q;
    logic [VAL_W-1:0] shadow_q [NUM_ITEMS];
    logic             shadow_we;

    logic [1:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             key_any;
    logic             key_multi;
    logic [1:0]       key_code;
    logic [1:0]       pop_code;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             drop;
    logic             tmo_hit;
    logic             changed;

    // ------------------------------------------------------------------
    // Key intake: keep only the highest-priority key of a collision.
    // ------------------------------------------------------------------
    assign key_any   = |key_pulse;
    assign key_multi = (key_pulse & (key_pulse - 4'd1)) != 4'd0;

    always_comb begin
        key_code = KEY_PREV;
        if (key_pulse[3])      key_code = KEY_CANCEL;
        else if (key_pulse[2]) key_code = KEY_OKAY;
        else if (key_pulse[1]) key_code = KEY_NEXT;
    end

    // ------------------------------------------------------------------
    // Key FIFO. A pop in the same cycle frees the slot a full FIFO needs,
    // so a push is only refused when full and nothing leaves.
    // ------------------------------------------------------------------
    assign fifo_full = (count_q == FULL_CNT);
    assign pop       = en && (count_q != '0) &&
                       (state_q == S_BROWSE || state_q == S_EDIT);
    assign push      = en && key_any && (!fifo_full || pop);
    assign drop      = en && key_any && fifo_full && !pop;
    assign pop_code  = fifo_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!en) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Sticky overflow, cleared only by reset or disable.
    assign ovf_d = en ? (ovf_q | key_multi | drop) : 1'b0;

    // FIFO storage carries no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= key_code;
    end

    // ------------------------------------------------------------------
    // EDIT inactivity timeout (optional).
    // ------------------------------------------------------------------
`ifdef MENU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counts idle EDIT cycles; leaving EDIT or popping a key restarts it,
    // so entry into EDIT always begins from zero.
    always_comb begin
        tmo_d = '0;
        if (en && state_q == S_EDIT && !pop) tmo_d = tmo_q + 1'b1;
    end

    assign tmo_hit = en && (state_q == S_EDIT) && !pop &&
                     (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Menu FSM. Outside EDIT/COMMIT/WAIT_ACK the displayed value always
    // tracks the stored value of the current item, so every path back to
    // BROWSE reloads it from the shadow registers.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        val_d     = val_q;
        req_d     = req_q;
        addr_d    = addr_q;
        data_d    = data_q;
        shadow_we = 1'b0;

        if (!en) begin
            // Flush: abort any commit, keep index and stored values.
            state_d = S_BROWSE;
            req_d   = 1'b0;
            val_d   = shadow_q[idx_q];
        end else begin
            case (state_q)
                S_BROWSE: begin
                    if (pop) begin
                        case (pop_code)
                            KEY_PREV: begin
                                idx_d = (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;
                                val_d = shadow_q[idx_d];
                            end
                            KEY_NEXT: begin
                                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                                val_d = shadow_q[idx_d];
                            end
                            KEY_OKAY: begin
                                val_d   = shadow_q[idx_q];
                                state_d = S_EDIT;
                            end
                            default: begin
                                idx_d = '0;
                                val_d = shadow_q[0];
                            end
                        endcase
                    end
                end

                S_EDIT: begin
                    if (pop) begin
                        case (pop_code)
                            KEY_PREV: val_d = (val_q == '0) ? val_q : val_q - 1'b1;
                            KEY_NEXT: val_d = (val_q == VAL_MAX) ? val_q : val_q + 1'b1;
                            KEY_OKAY: state_d = S_COMMIT;
                            default: begin
                                val_d   = shadow_q[idx_q];
                                state_d = S_BROWSE;
                            end
                        endcase
                    end else if (tmo_hit) begin
                        val_d   = shadow_q[idx_q];
                        state_d = S_BROWSE;
                    end
                end

                S_COMMIT: begin
                    addr_d  = idx_q;
                    data_d  = val_q;
                    req_d   = 1'b1;
                    state_d = S_WAIT_ACK;
                end

                default: begin
                    // edit_val already equals the committed value, so it
                    // stays put while the shadow register catches up.
                    if (cfg_ack) begin
                        shadow_we = 1'b1;
                        req_d     = 1'b0;
                        state_d   = S_BROWSE;
                    end
                end
            endcase
        end
    end

    assign changed = (idx_d != idx_q) || (val_d != val_q) ||
                     ((state_d == S_EDIT) != (state_q == S_EDIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_BROWSE;
            idx_q     <= '0;
            val_q     <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            refresh_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            val_q     <= val_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
            refresh_q <= changed;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) shadow_q[i] <= '0;
        end else if (shadow_we) begin
            shadow_q[addr_q] <= data_q;
        end
    end

    assign menu_idx     = idx_q;
    assign edit_val     = val_q;
    assign editing      = (state_q == S_EDIT);
    assign cfg_req      = req_q;
    assign cfg_addr     = addr_q;
    assign cfg_data     = data_q;
    assign disp_refresh = refresh_q;
    assign key_ovf      = ovf_q;

endmodule

// File: tb/tb_key_menu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_key_menu_sequencer
//
// Directed steps followed by a randomized phase. A queue-based reference model
// of the menu (pending keys, mode, index, value, stored values) predicts every
// observable output after each clock edge.
// ---------------------------------------------------------------------------
module tb_key_menu_sequencer;

    localparam int NI   = 8;
    localparam int IW   = 3;
    localparam int VW   = 8;
    localparam int FD   = 4;
    localparam int TMO  = 100;
    localparam int VMAX = (1 << VW) - 1;

    localparam int MB = 0;  // browsing
    localparam int ME = 1;  // editing
    localparam int MC = 2;  // commit issue
    localparam int MW = 3;  // waiting for ack

    localparam logic [3:0] K_NONE   = 4'b0000;
    localparam logic [3:0] K_PREV   = 4'b0001;
    localparam logic [3:0] K_NEXT   = 4'b0010;
    localparam logic [3:0] K_OKAY   = 4'b0100;
    localparam logic [3:0] K_CANCEL = 4'b1000;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [3:0]    key_pulse;
    logic [IW-1:0] menu_idx;
    logic [VW-1:0] edit_val;
    logic          editing;
    logic          cfg_req;
    logic [IW-1:0] cfg_addr;
    logic [VW-1:0] cfg_data;
    logic          cfg_ack;
    logic          disp_refresh;
    logic          key_ovf;

    key_menu_sequencer #(
        .NUM_ITEMS  (NI),
        .IDX_W      (IW),
        .VAL_W      (VW),
        .FIFO_DEPTH (FD),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .key_pulse   (key_pulse),
        .menu_idx    (menu_idx),
        .edit_val    (edit_val),
        .editing     (editing),
        .cfg_req     (cfg_req),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_ack     (cfg_ack),
        .disp_refresh(disp_refresh),
        .key_ovf     (key_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int nref   = 0;

    // Reference model state
    int m_q[$];
    int m_mode, m_idx, m_val, m_req, m_addr, m_data, m_ovf, m_ref;
    int m_shadow[NI];
`ifdef MENU_TIMEOUT_EN
    int m_idle;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_mode = MB; m_idx = 0; m_val = 0; m_req = 0;
        m_addr = 0;  m_data = 0; m_ovf = 0; m_ref = 0;
        for (int i = 0; i < NI; i++) m_shadow[i] = 0;
`ifdef MENU_TIMEOUT_EN
        m_idle = 0;
`endif
    endtask

    // Advance the model across one clock edge given the inputs of that cycle.
    task automatic model_step(input logic [3:0] k, input logic a, input logic e);
        int p_idx = m_idx;
        int p_val = m_val;
        int p_ed  = (m_mode == ME);
        int key   = -1;
        int code;
        if (!e) begin
            m_q.delete();
            m_ovf  = 0;
            m_mode = MB;
            m_req  = 0;
        end else begin
            if (m_q.size() > 0 && (m_mode == MB || m_mode == ME)) key = m_q.pop_front();
            if (k != 4'b0000) begin
                code = k[3] ? 3 : k[2] ? 2 : k[1] ? 1 : 0;
                if ($countones(k) > 1) m_ovf = 1;
                if (m_q.size() < FD) m_q.push_back(code);
                else m_ovf = 1;
            end
            case (m_mode)
                MB: begin
                    if (key == 0) m_idx = (m_idx + NI - 1) % NI;
                    else if (key == 1) m_idx = (m_idx + 1) % NI;
                    else if (key == 2) m_mode = ME;
                    else if (key == 3) m_idx = 0;
                end
                ME: begin
                    if (key == 0) m_val = (m_val > 0) ? m_val - 1 : 0;
                    else if (key == 1) m_val = (m_val < VMAX) ? m_val + 1 : VMAX;
                    else if (key == 2) m_mode = MC;
                    else if (key == 3) m_mode = MB;
`ifdef MENU_TIMEOUT_EN
                    if (m_mode == ME) begin
                        if (key >= 0) m_idle = 0;
                        else begin
                            m_idle++;
                            if (m_idle == TMO) m_mode = MB;
                        end
                    end
`endif
                end
                MC: begin
                    m_addr = m_idx; m_data = m_val; m_req = 1; m_mode = MW;
                end
                default: begin
                    if (a) begin
                        m_shadow[m_addr] = m_data; m_req = 0; m_mode = MB;
                    end
                end
            endcase
        end
`ifdef MENU_TIMEOUT_EN
        if (m_mode != ME) m_idle = 0;
`endif
        // While browsing the shown value is the stored value of the item.
        if (m_mode == MB) m_val = m_shadow[m_idx];
        m_ref = ((p_idx != m_idx) || (p_val != m_val) || (p_ed != (m_mode == ME))) ? 1 : 0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".menu_idx"}, menu_idx, m_idx);
        chk({tag, ".edit_val"}, edit_val, m_val);
        chk({tag, ".editing"}, editing, (m_mode == ME) ? 1 : 0);
        chk({tag, ".cfg_req"}, cfg_req, m_req);
        chk({tag, ".disp_refresh"}, disp_refresh, m_ref);
        chk({tag, ".key_ovf"}, key_ovf, m_ovf);
        if (m_req != 0) begin
            chk({tag, ".cfg_addr"}, cfg_addr, m_addr);
            chk({tag, ".cfg_data"}, cfg_data, m_data);
        end
    endtask

    task automatic tick(input logic [3:0] k, input logic a, input string tag);
        key_pulse = k;
        cfg_ack   = a;
        @(posedge clk);
        model_step(k, a, en);
        #1;
        key_pulse = K_NONE;
        cfg_ack   = 1'b0;
        compare_all(tag);
        if (disp_refresh === 1'b1) nref++;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(K_NONE, 1'b0, tag);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 10; i++) begin
            if (cfg_req === 1'b1) break;
            tick(K_NONE, 1'b0, tag);
        end
        chk({tag, ".req_seen"}, cfg_req, 1);
    endtask

    initial begin
        logic [3:0] rk;
        logic       ra;
        int         base_idx;

        rst_n     = 1'b0;
        en        = 1'b0;
        key_pulse = K_NONE;
        cfg_ack   = 1'b0;
        model_reset();
        #12;
        chk("reset.menu_idx", menu_idx, 0);
        chk("reset.edit_val", edit_val, 0);
        chk("reset.editing", editing, 0);
        chk("reset.cfg_req", cfg_req, 0);
        chk("reset.disp_refresh", disp_refresh, 0);
        chk("reset.key_ovf", key_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // Nine Next pulses wrap the 8-item menu once and land on item 1.
        nref = 0;
        for (int i = 0; i < 9; i++) tick(K_NEXT, 1'b0, "next9");
        idle(2, "next9");
        chk("next9.idx", menu_idx, 1);
        chk("next9.refresh_count", nref, 9);

        // Cancel returns to item 0, Prev wraps to 7.
        tick(K_CANCEL, 1'b0, "cancel_browse"); idle(2, "cancel_browse");
        chk("cancel_browse.idx", menu_idx, 0);
        tick(K_PREV, 1'b0, "prev_wrap"); idle(2, "prev_wrap");
        chk("prev_wrap.idx", menu_idx, 7);

        // Edit item 7 to 3 and commit with a slow ack.
        tick(K_OKAY, 1'b0, "edit7"); idle(2, "edit7");
        chk("edit7.editing", editing, 1);
        for (int i = 0; i < 3; i++) tick(K_NEXT, 1'b0, "edit7.inc");
        idle(2, "edit7.inc");
        chk("edit7.val", edit_val, 3);
        tick(K_OKAY, 1'b0, "commit7");
        wait_req("commit7");
        for (int i = 0; i < 5; i++) tick(K_NONE, 1'b0, "commit7.hold");
        chk("commit7.req_held", cfg_req, 1);
        chk("commit7.addr", cfg_addr, 7);
        chk("commit7.data", cfg_data, 3);
        tick(K_NONE, 1'b1, "commit7.ack");
        chk("commit7.req_drop", cfg_req, 0);
        chk("commit7.browse", editing, 0);
        chk("commit7.shadow", edit_val, 3);
        tick(K_NONE, 1'b1, "stray_ack");
        idle(2, "stray_ack");

        // Two keys in one cycle: only Okay is taken, overflow flagged.
        tick(K_NEXT | K_OKAY, 1'b0, "collide"); idle(2, "collide");
        chk("collide.editing", editing, 1);
        chk("collide.idx", menu_idx, 7);
        chk("collide.ovf", key_ovf, 1);
        tick(K_CANCEL, 1'b0, "collide.cancel"); idle(2, "collide.cancel");
        en = 1'b0;
        tick(K_NONE, 1'b0, "disable");
        chk("disable.ovf_clear", key_ovf, 0);
        en = 1'b1;

        // Six Next pulses during WAIT_ACK: four survive in the FIFO.
        tick(K_OKAY, 1'b0, "burst"); idle(2, "burst");
        tick(K_OKAY, 1'b0, "burst");
        wait_req("burst");
        for (int i = 0; i < 6; i++) tick(K_NEXT, 1'b0, "burst.keys");
        tick(K_NONE, 1'b1, "burst.ack");
        idle(8, "burst.drain");
        chk("burst.idx", menu_idx, 3);
        chk("burst.ovf", key_ovf, 1);

        // Saturation at both ends produces no refresh.
        tick(K_OKAY, 1'b0, "sat"); idle(2, "sat");
        nref = 0;
        tick(K_PREV, 1'b0, "sat.low"); idle(2, "sat.low");
        chk("sat.low.refresh_count", nref, 0);
        chk("sat.low.val", edit_val, 0);
        for (int i = 0; i < VMAX; i++) tick(K_NEXT, 1'b0, "sat.ramp");
        idle(2, "sat.ramp");
        chk("sat.ramp.val", edit_val, 255);
        nref = 0;
        tick(K_NEXT, 1'b0, "sat.high"); idle(2, "sat.high");
        chk("sat.high.refresh_count", nref, 0);
        chk("sat.high.val", edit_val, 255);

        // Disable during WAIT_ACK aborts the commit and flushes queued keys.
        tick(K_OKAY, 1'b0, "abort");
        wait_req("abort");
        tick(K_NEXT, 1'b0, "abort.queue");
        tick(K_NEXT, 1'b0, "abort.queue");
        en = 1'b0;
        tick(K_NONE, 1'b0, "abort.en_low");
        chk("abort.req", cfg_req, 0);
        en = 1'b1;
        idle(4, "abort.after");
        chk("abort.idx", menu_idx, 3);
        chk("abort.shadow", edit_val, 0);
        chk("abort.editing", editing, 0);

        // Long idle in EDIT.
        tick(K_OKAY, 1'b0, "idle_edit"); idle(2, "idle_edit");
        tick(K_NEXT, 1'b0, "idle_edit"); idle(2, "idle_edit");
        idle(1000, "idle_edit.wait");
`ifdef MENU_TIMEOUT_EN
        chk("timeout.editing", editing, 0);
        chk("timeout.val", edit_val, 0);
`else
        chk("no_timeout.editing", editing, 1);
        chk("no_timeout.val", edit_val, 1);
`endif
        tick(K_CANCEL, 1'b0, "idle_edit.exit"); idle(2, "idle_edit.exit");

        // Randomized phase against the model.
        for (int i = 0; i < 600; i++) begin
            rk = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : K_NONE;
            ra = (m_req != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            en = ($urandom_range(0, 99) != 0);
            tick(rk, ra, "random");
        end
        en = 1'b1;

        // Asynchronous reset in the middle of a commit.
        en = 1'b0; tick(K_NONE, 1'b0, "areset.prep");
        en = 1'b1;
        tick(K_OKAY, 1'b0, "areset.prep"); idle(2, "areset.prep");
        tick(K_OKAY, 1'b0, "areset.prep");
        wait_req("areset");
        base_idx = m_idx;
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.req", cfg_req, 0);
        chk("areset.idx", menu_idx, 0);
        chk("areset.ovf", key_ovf, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick(K_NEXT, 1'b0, "areset.after"); idle(2, "areset.after");
        chk("areset.after.idx", menu_idx, 1);
        chk("areset.prior_idx_valid", (base_idx < NI) ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
